// File: rtl/exec_halt_controller.sv
// exec_halt_controller: run/step/halt gate for the execution driver with opcode, breakpoint, external and step-done halts
module exec_halt_controller #(
  parameter int OPCODE_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter logic [OPCODE_SIZE-1:0] HALT_OPCODE = 8'h01,
  parameter int NUM_BP = 4,
  parameter int STEP_W = 8,
  parameter bit RESET_HALTED = 1'b0,
  localparam int IDX_W = NUM_BP > 1 ? $clog2(NUM_BP) : 1
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [ADDR_SIZE-1:0]   pc,
  input  logic                   halt_req,
  input  logic                   resume,
  input  logic                   step_req,
  input  logic [STEP_W-1:0]      step_count,
  input  logic                   bp_wr,
  input  logic [IDX_W-1:0]       bp_idx,
  input  logic [ADDR_SIZE-1:0]   bp_addr,
  input  logic                   bp_en,
  output logic                   exec_enable,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic [IDX_W-1:0]       bp_hit_idx
);
  typedef enum logic [1:0] {RUN, STEP, HALTED} state_t;
  state_t state, state_n;
  logic [STEP_W-1:0] cnt, cnt_n;
  logic [1:0] cause_n;
  logic [IDX_W-1:0] idx_n, bp_match_idx;
  logic bp_skip, skip_n, bp_match, op_hit, bp_hit, retire;
  logic [ADDR_SIZE-1:0] bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0] bp_en_q;
  // descending scan so the lowest matching entry is the one left standing
  always_comb begin
    bp_match = 1'b0;
    bp_match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (bp_en_q[i] && bp_addr_q[i] == pc) begin
        bp_match = 1'b1;
        bp_match_idx = IDX_W'(i);
      end
  end
  assign op_hit = instr_valid && opcode == HALT_OPCODE;
  assign bp_hit = instr_valid && !bp_skip && bp_match;
  assign exec_enable = state != HALTED && !op_hit && !bp_hit;
  assign retire = instr_valid && exec_enable;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cause_n = halt_cause;
    idx_n = bp_hit_idx;
    skip_n = bp_skip && !instr_valid;
    if (state != HALTED) begin
      if (op_hit || bp_hit || halt_req) begin
        state_n = HALTED;
        cnt_n = '0;
        cause_n = op_hit ? 2'd1 : bp_hit ? 2'd2 : 2'd0;
        idx_n = !op_hit && bp_hit ? bp_match_idx : bp_hit_idx;
      end else if (state == STEP && resume) begin
        state_n = RUN;
        cnt_n = '0;
      end else if (state == STEP && retire) begin
        cnt_n = cnt - 1'b1;
        state_n = cnt == STEP_W'(1) ? HALTED : STEP;
        cause_n = cnt == STEP_W'(1) ? 2'd3 : halt_cause;
      end
    end else if (resume) begin
      state_n = RUN;
      skip_n = 1'b1;
    end else if (step_req && step_count != '0) begin
      state_n = STEP;
      cnt_n = step_count;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_HALTED ? HALTED : RUN;
      halted <= RESET_HALTED;
      halt_cause <= '0;
      bp_hit_idx <= '0;
      cnt <= '0;
      bp_skip <= 1'b0;
    end else begin
      state <= state_n;
      halted <= state_n == HALTED;
      halt_cause <= cause_n;
      bp_hit_idx <= idx_n;
      cnt <= cnt_n;
      bp_skip <= skip_n;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_en_q <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else if (bp_wr && int'(bp_idx) < NUM_BP) begin
      bp_en_q[bp_idx] <= bp_en;
      bp_addr_q[bp_idx] <= bp_addr;
    end
  end
endmodule

// File: tb/tb_exec_halt_controller.sv
// tb_exec_halt_controller: directed and random checks against a run/remaining-instructions reference model
module tb_exec_halt_controller;
  logic clk = 0, rst = 1;
  logic instr_valid = 0, halt_req = 0, resume = 0, step_req = 0, bp_wr = 0, bp_en = 0;
  logic [7:0] opcode = 0, pc = 0, step_count = 0, bp_addr = 0;
  logic [1:0] bp_idx = 0;
  logic exec_enable, halted;
  logic [1:0] halt_cause, bp_hit_idx;
  int checks = 0, errors = 0, ee_cnt = 0;
  bit m_run, m_skip;
  int m_left, m_cause, m_idx;
  bit m_en [4];
  int m_addr [4];

  exec_halt_controller dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .pc(pc),
    .halt_req(halt_req), .resume(resume), .step_req(step_req), .step_count(step_count),
    .bp_wr(bp_wr), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en(bp_en),
    .exec_enable(exec_enable), .halted(halted), .halt_cause(halt_cause), .bp_hit_idx(bp_hit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1; m_skip = 0; m_left = 0; m_cause = 0; m_idx = 0;
    for (int i = 0; i < 4; i++) begin m_en[i] = 0; m_addr[i] = 0; end
  endtask

  function automatic void model_eval(output bit op, output bit bp, output int bi, output bit ee);
    op = instr_valid && opcode == 8'h01;
    bp = 0; bi = 0;
    if (instr_valid && !m_skip)
      for (int i = 0; i < 4; i++)
        if (!bp && m_en[i] && m_addr[i] == int'(pc)) begin bp = 1; bi = i; end
    ee = m_run && !op && !bp;
  endfunction

  task automatic model_tick();
    bit op, bp, ee, was_halted;
    int bi;
    was_halted = !m_run;
    model_eval(op, bp, bi, ee);
    if (m_run) begin
      if (op || bp || halt_req) begin
        m_run = 0; m_left = 0;
        m_cause = op ? 1 : bp ? 2 : 0;
        if (!op && bp) m_idx = bi;
      end else if (m_left > 0 && resume) m_left = 0;
      else if (m_left > 0 && instr_valid && ee) begin
        m_left--;
        if (m_left == 0) begin m_run = 0; m_cause = 3; end
      end
    end else if (resume) m_run = 1;
    else if (step_req && step_count != 0) begin m_run = 1; m_left = int'(step_count); end
    m_skip = (was_halted && resume) ? 1'b1 : (m_skip && !instr_valid);
    if (bp_wr) begin m_en[bp_idx] = bp_en; m_addr[bp_idx] = int'(bp_addr); end
  endtask

  task automatic check_regs();
    chk("halted", {7'd0, halted}, m_run ? 8'd0 : 8'd1);
    chk("halt_cause", {6'd0, halt_cause}, 8'(m_cause));
    chk("bp_hit_idx", {6'd0, bp_hit_idx}, 8'(m_idx));
  endtask

  // inputs are applied at posedge+1; combinational output checked at +3, registers at next posedge+1
  task automatic tick();
    bit op, bp, ee;
    int bi;
    #2;
    model_eval(op, bp, bi, ee);
    chk("exec_enable", {7'd0, exec_enable}, {7'd0, ee});
    if (exec_enable) ee_cnt++;
    model_tick();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic set(input bit iv, input logic [7:0] opc, input logic [7:0] p,
                     input bit hr, input bit rs, input bit sr, input logic [7:0] sc);
    instr_valid = iv; opcode = opc; pc = p; halt_req = hr; resume = rs;
    step_req = sr; step_count = sc; bp_wr = 0;
  endtask

  task automatic wbp(input logic [1:0] idx, input logic [7:0] a, input bit en);
    set(0, 0, 0, 0, 0, 0, 0);
    bp_wr = 1; bp_idx = idx; bp_addr = a; bp_en = en;
    tick();
    bp_wr = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_regs();
    // opcode halt from RUN
    set(1, 8'h01, 8'h00, 0, 0, 0, 0); tick();
    chk("t1_halted", {7'd0, halted}, 8'd1);
    chk("t1_cause", {6'd0, halt_cause}, 8'd1);
    set(0, 0, 0, 0, 1, 0, 0); tick();
    // breakpoint at 0x40 then resume over it
    wbp(2, 8'h40, 1);
    set(1, 8'h00, 8'h3E, 0, 0, 0, 0); tick();
    set(1, 8'h00, 8'h3F, 0, 0, 0, 0); tick();
    set(1, 8'h00, 8'h40, 0, 0, 0, 0); tick();
    chk("t2_cause", {6'd0, halt_cause}, 8'd2);
    chk("t2_idx", {6'd0, bp_hit_idx}, 8'd2);
    set(1, 8'h00, 8'h40, 0, 1, 0, 0); tick();
    set(1, 8'h00, 8'h40, 0, 0, 0, 0); #2;
    chk("t2_no_rehit", {7'd0, exec_enable}, 8'd1);
    tick();
    wbp(2, 8'h40, 0);
    // step burst of 3, then zero-length step ignored
    set(0, 0, 0, 1, 0, 0, 0); tick();
    set(0, 0, 0, 0, 0, 1, 8'd3); tick();
    ee_cnt = 0;
    for (int i = 0; i < 3; i++) begin set(1, 8'h00, 8'(8'h10 + i), 0, 0, 0, 0); tick(); end
    chk("t3_ee_count", 8'(ee_cnt), 8'd3);
    chk("t3_cause", {6'd0, halt_cause}, 8'd3);
    set(1, 8'h00, 8'h13, 0, 0, 1, 8'd0); tick();
    chk("t3_zero_step", {7'd0, halted}, 8'd1);
    // halt opcode mid-burst
    set(0, 0, 0, 0, 0, 1, 8'd5); tick();
    set(1, 8'h00, 8'h20, 0, 0, 0, 0); tick();
    set(1, 8'h01, 8'h21, 0, 0, 0, 0); tick();
    chk("t4_cause", {6'd0, halt_cause}, 8'd1);
    set(0, 0, 0, 0, 1, 0, 0); tick();
    chk("t4_resume", {7'd0, halted}, 8'd0);
    // external halt, then resume+step together
    set(1, 8'h00, 8'h30, 1, 0, 0, 0); tick();
    chk("t5_cause", {6'd0, halt_cause}, 8'd0);
    set(0, 0, 0, 0, 1, 1, 8'd2); tick();
    chk("t5_resume_wins", {7'd0, halted}, 8'd0);
    set(1, 8'h00, 8'h31, 0, 0, 0, 0); tick();
    // reset in the middle of a burst
    wbp(1, 8'h50, 1);
    set(1, 8'h00, 8'h50, 0, 0, 0, 0); tick();
    set(0, 0, 0, 0, 0, 1, 8'd6); tick();
    set(1, 8'h00, 8'h51, 0, 0, 0, 0); tick();
    set(1, 8'h00, 8'h52, 0, 0, 0, 0); #2;
    rst = 1; #1;
    chk("t6_rst_halted", {7'd0, halted}, 8'd0);
    chk("t6_rst_cause", {6'd0, halt_cause}, 8'd0);
    chk("t6_rst_idx", {6'd0, bp_hit_idx}, 8'd0);
    @(posedge clk); #1 rst = 0;
    model_reset();
    set(1, 8'h00, 8'h50, 0, 0, 0, 0); #2;
    chk("t6_bp_cleared", {7'd0, exec_enable}, 8'd1);
    tick();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      set($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0 ? 8'h01 : 8'(8'h02 + $urandom_range(3, 0)),
          8'(8'h60 + $urandom_range(7, 0)), $urandom_range(19, 0) == 0, $urandom_range(7, 0) == 0,
          $urandom_range(5, 0) == 0, 8'($urandom_range(4, 0)));
      if ($urandom_range(9, 0) == 0) begin
        bp_wr = 1; bp_idx = 2'($urandom_range(3, 0));
        bp_addr = 8'(8'h60 + $urandom_range(7, 0)); bp_en = 1'($urandom_range(1, 0));
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
